// File: rtl/btb_ram_pkg.sv
// -----------------------------------------------------------------------------
// btb_ram_pkg
//   Shared types for the multi-ported branch-target RAM.
//   Only the control state type lives here; all sizing (port counts, depth,
//   index and entry width, bypass, clear value) is set per instance through
//   module parameters.
// -----------------------------------------------------------------------------
package btb_ram_pkg;

  // CLEAR : the sweep is writing INIT_VAL to every entry, user traffic ignored
  // READY : array initialised, user writes accepted
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } btb_state_e;

endpackage : btb_ram_pkg

// File: rtl/btb_ram_wr_sel.sv
// -----------------------------------------------------------------------------
// btb_ram_wr_sel
//   Combinational write-port priority resolver. Looks at all write ports and
//   reports whether any enabled, in-range port targets cmp_addr_i, together
//   with the data of the winning port. When several ports hit, the highest
//   port index wins, matching the write order used by the array itself.
//
// Ports
//   we_i       in  WPORT         write enables
//   addr_i     in  WPORT x INDEX write addresses
//   data_i     in  WPORT x WIDTH write data
//   cmp_addr_i in  INDEX         address to compare against
//   hit_o      out 1             at least one enabled in-range port matches
//   data_o     out WIDTH         data of the highest-index matching port
// -----------------------------------------------------------------------------
module btb_ram_wr_sel
  import btb_ram_pkg::*;
#(
  parameter int WPORT = 2,
  parameter int INDEX = 6,
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic [WPORT-1:0]            we_i,
  input  logic [WPORT-1:0][INDEX-1:0] addr_i,
  input  logic [WPORT-1:0][WIDTH-1:0] data_i,
  input  logic [INDEX-1:0]            cmp_addr_i,
  output logic                        hit_o,
  output logic [WIDTH-1:0]            data_o
);

  // One extra bit so DEPTH == 2**INDEX still compares correctly.
  localparam logic [INDEX:0] DEPTH_W = (INDEX + 1)'(DEPTH);

  // Ascending scan: a later (higher-index) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int w = 0; w < WPORT; w++) begin
      if (we_i[w] && ({1'b0, addr_i[w]} < DEPTH_W) && (addr_i[w] == cmp_addr_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[w];
      end
    end
  end

endmodule : btb_ram_wr_sel

// File: rtl/btb_ram_mp.sv
// -----------------------------------------------------------------------------
// btb_ram_mp
//   Multi-ported branch-target storage for the fetch stage.
//   RPORT combinational read ports, WPORT synchronous write ports with fixed
//   priority (highest port index wins on an address collision) and optional
//   same-cycle write-to-read forwarding. A clear sequencer walks every entry
//   to INIT_VAL after reset or on flush, so predictor state is never read
//   before it has been initialised.
//
// Ports
//   clk           in  1             clock, all state on rising edge
//   reset_n       in  1             synchronous active-low reset
//   flush_i       in  1             request full-array clear
//   ready_o       out 1             array cleared, writes accepted (registered)
//   addr_i        in  RPORT x INDEX read addresses
//   data_o        out RPORT x WIDTH read data (combinational)
//   addrwr_i      in  WPORT x INDEX write addresses
//   datawr_i      in  WPORT x WIDTH write data
//   we_i          in  WPORT         write enables
//   wr_conflict_o out 1             registered pulse: two or more enabled
//                                   in-range write ports hit one address
//                                   in the previous cycle
// -----------------------------------------------------------------------------
module btb_ram_mp
  import btb_ram_pkg::*;
#(
  parameter int               RPORT    = 2,
  parameter int               WPORT    = 2,
  parameter int               DEPTH    = 64,
  parameter int               INDEX    = 6,
  parameter int               WIDTH    = 32,
  parameter bit               BYPASS   = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush_i,
  output logic                        ready_o,
  input  logic [RPORT-1:0][INDEX-1:0] addr_i,
  output logic [RPORT-1:0][WIDTH-1:0] data_o,
  input  logic [WPORT-1:0][INDEX-1:0] addrwr_i,
  input  logic [WPORT-1:0][WIDTH-1:0] datawr_i,
  input  logic [WPORT-1:0]            we_i,
  output logic                        wr_conflict_o
);

  // Storage is indexed with just enough bits for DEPTH entries; every access
  // is range-checked first, so dropping the upper INDEX bits is safe.
  localparam int               AW       = $clog2(DEPTH);
  localparam logic [INDEX:0]   DEPTH_W  = (INDEX + 1)'(DEPTH);
  localparam logic [INDEX-1:0] LAST_IDX = INDEX'(DEPTH - 1);

  function automatic logic in_range(input logic [INDEX-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  btb_state_e       state_reg, state_next;
  logic [INDEX-1:0] clr_ptr_reg, clr_ptr_next;
  logic             wr_conflict_reg, wr_conflict_next;
  logic [WPORT-1:0] conflict_vec;
  logic             is_ready;

  assign is_ready      = (state_reg == READY);
  assign ready_o       = is_ready;
  assign wr_conflict_o = wr_conflict_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= CLEAR;
      clr_ptr_reg     <= '0;
      wr_conflict_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clr_ptr_reg     <= clr_ptr_next;
      wr_conflict_reg <= wr_conflict_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    // Conflicts only count while user writes are actually being accepted.
    wr_conflict_next = is_ready && (|conflict_vec);
    case (state_reg)
      CLEAR: begin
        if (flush_i) begin
          // A flush mid-sweep restarts the walk so the whole array is
          // guaranteed fresh relative to the latest flush.
          clr_ptr_next = '0;
        end else if (clr_ptr_reg == LAST_IDX) begin
          state_next   = READY;
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr_reg + INDEX'(1);
        end
      end
      READY: begin
        if (flush_i) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_ptr_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage. Kept as a plain array with no reset so it can later be swapped
  // for a compiled memory macro without touching the control logic.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_reg == CLEAR) begin
        ram[clr_ptr_reg[AW-1:0]] <= INIT_VAL;
      end else begin
        // Ascending port order: the last non-blocking write to an address
        // sticks, giving the highest-index port priority.
        for (int w = 0; w < WPORT; w++) begin
          if (we_i[w] && in_range(addrwr_i[w])) begin
            ram[addrwr_i[w][AW-1:0]] <= datawr_i[w];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports, each with its own resolver for same-cycle forwarding.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < RPORT; gi++) begin : g_rd
      logic             byp_hit;
      logic [WIDTH-1:0] byp_data;
      logic [WIDTH-1:0] rd_data;

      btb_ram_wr_sel #(
        .WPORT (WPORT),
        .INDEX (INDEX),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_rd_sel (
        .we_i       (we_i),
        .addr_i     (addrwr_i),
        .data_i     (datawr_i),
        .cmp_addr_i (addr_i[gi]),
        .hit_o      (byp_hit),
        .data_o     (byp_data)
      );

      // During the sweep, or for an out-of-range address, the array content
      // is not meaningful to the caller, so INIT_VAL is returned instead.
      always_comb begin
        rd_data = INIT_VAL;
        if (is_ready && in_range(addr_i[gi])) begin
          rd_data = ram[addr_i[gi][AW-1:0]];
          if (BYPASS && byp_hit) begin
            rd_data = byp_data;
          end
        end
      end

      assign data_o[gi] = rd_data;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Conflict detection: port gi conflicts when it is an enabled in-range write
  // and some *other* enabled port targets the same address. The resolver is
  // reused with port gi masked out of the enable vector.
  // ---------------------------------------------------------------------------
  logic [WPORT-1:0][WIDTH-1:0] unused_cf_data;

  generate
    for (gi = 0; gi < WPORT; gi++) begin : g_cf
      logic [WPORT-1:0] other_we;
      logic             other_hit;

      assign other_we = we_i & ~(WPORT'(1) << gi);

      btb_ram_wr_sel #(
        .WPORT (WPORT),
        .INDEX (INDEX),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_cf_sel (
        .we_i       (other_we),
        .addr_i     (addrwr_i),
        .data_i     (datawr_i),
        .cmp_addr_i (addrwr_i[gi]),
        .hit_o      (other_hit),
        .data_o     (unused_cf_data[gi])
      );

      assign conflict_vec[gi] = we_i[gi] && in_range(addrwr_i[gi]) && other_hit;
    end
  endgenerate

endmodule : btb_ram_mp

// File: tb/tb_btb_ram_mp.sv
// -----------------------------------------------------------------------------
// tb_btb_ram_mp
//   Three instances share one clock:
//     A : default build (DEPTH 64, BYPASS 1, INIT_VAL 0)
//     B : BYPASS 0, DEPTH 16, INDEX 4
//     C : DEPTH 48, INDEX 6, non-zero INIT_VAL (out-of-range behaviour)
//   Each instance has an array model of the expected contents; expected reads
//   follow the rule "last enabled matching write port wins, else memory".
// -----------------------------------------------------------------------------
module tb_btb_ram_mp;

  localparam logic [31:0] C_INIT = 32'hA5A5_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A ----------------
  logic             a_reset_n, a_flush, a_ready, a_conf;
  logic [1:0][5:0]  a_addr, a_addrwr;
  logic [1:0][31:0] a_data, a_datawr;
  logic [1:0]       a_we;
  logic [31:0]      a_mem [64];

  btb_ram_mp #(
    .RPORT(2), .WPORT(2), .DEPTH(64), .INDEX(6), .WIDTH(32),
    .BYPASS(1'b1), .INIT_VAL(32'h0)
  ) u_dut_a (
    .clk(clk), .reset_n(a_reset_n), .flush_i(a_flush), .ready_o(a_ready),
    .addr_i(a_addr), .data_o(a_data), .addrwr_i(a_addrwr),
    .datawr_i(a_datawr), .we_i(a_we), .wr_conflict_o(a_conf)
  );

  // ---------------- instance B ----------------
  logic             b_reset_n, b_flush, b_ready, b_conf;
  logic [1:0][3:0]  b_addr, b_addrwr;
  logic [1:0][31:0] b_data, b_datawr;
  logic [1:0]       b_we;
  logic [31:0]      b_mem [16];

  btb_ram_mp #(
    .RPORT(2), .WPORT(2), .DEPTH(16), .INDEX(4), .WIDTH(32),
    .BYPASS(1'b0), .INIT_VAL(32'h0)
  ) u_dut_b (
    .clk(clk), .reset_n(b_reset_n), .flush_i(b_flush), .ready_o(b_ready),
    .addr_i(b_addr), .data_o(b_data), .addrwr_i(b_addrwr),
    .datawr_i(b_datawr), .we_i(b_we), .wr_conflict_o(b_conf)
  );

  // ---------------- instance C ----------------
  logic             c_reset_n, c_flush, c_ready, c_conf;
  logic [1:0][5:0]  c_addr, c_addrwr;
  logic [1:0][31:0] c_data, c_datawr;
  logic [1:0]       c_we;
  logic [31:0]      c_mem [48];

  btb_ram_mp #(
    .RPORT(2), .WPORT(2), .DEPTH(48), .INDEX(6), .WIDTH(32),
    .BYPASS(1'b1), .INIT_VAL(C_INIT)
  ) u_dut_c (
    .clk(clk), .reset_n(c_reset_n), .flush_i(c_flush), .ready_o(c_ready),
    .addr_i(c_addr), .data_o(c_data), .addrwr_i(c_addrwr),
    .datawr_i(c_datawr), .we_i(c_we), .wr_conflict_o(c_conf)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [5:0] wa;
    a_reset_n = 1'b0;
    a_we      = '0;
    step();
    step();
    checks++;
    if (a_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%0b exp=0", a_ready);
    end
    checks++;
    if (a_conf !== 1'b0) begin
      failures++; $display("FAIL reset_conflict got=%0b exp=0", a_conf);
    end
    a_reset_n = 1'b1;
    // Clear sweep: writes are offered (colliding, to tempt the conflict flag)
    // and reads must all see INIT_VAL.
    for (int k = 0; k < 64; k++) begin
      wa          = 6'($urandom_range(0, 63));
      a_we        = 2'b11;
      a_addrwr[0] = wa;
      a_addrwr[1] = wa;
      a_datawr[0] = $urandom();
      a_datawr[1] = $urandom();
      a_addr[0]   = 6'($urandom_range(0, 63));
      a_addr[1]   = wa;
      #1;
      checks++;
      if (a_data[0] !== 32'h0 || a_data[1] !== 32'h0) begin
        failures++;
        $display("FAIL clear_read k=%0d got=%h/%h exp=0", k, a_data[0], a_data[1]);
      end
      if (k == 63) a_we = 2'b00;
      @(posedge clk);
      #1;
      checks++;
      if (a_ready !== (k == 63)) begin
        failures++; $display("FAIL clear_ready k=%0d got=%0b exp=%0b", k, a_ready, (k == 63));
      end
      checks++;
      if (a_conf !== 1'b0) begin
        failures++; $display("FAIL clear_conflict k=%0d got=%0b exp=0", k, a_conf);
      end
    end
    a_we = '0;
    for (int i = 0; i < 64; i++) a_mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      a_addr[0] = 6'(2 * i);
      a_addr[1] = 6'(2 * i + 1);
      #1;
      checks++;
      if (a_data[0] !== 32'h0 || a_data[1] !== 32'h0) begin
        failures++;
        $display("FAIL post_clear_read addr=%0d got=%h/%h exp=0", 2 * i, a_data[0], a_data[1]);
      end
      step();
    end
    $display("txn reset: ready after 64 edges, array reads INIT_VAL");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write_pair();
    a_we        = 2'b11;
    a_addrwr[0] = 6'd5;  a_datawr[0] = 32'hDEAD_BEEF;
    a_addrwr[1] = 6'd9;  a_datawr[1] = 32'h0000_1234;
    a_addr[0]   = 6'd5;  a_addr[1]   = 6'd9;
    #1;
    checks++;
    if (a_data[0] !== 32'hDEAD_BEEF || a_data[1] !== 32'h1234) begin
      failures++;
      $display("FAIL pair_bypass got=%h/%h exp=deadbeef/00001234", a_data[0], a_data[1]);
    end
    step();
    a_we = '0;
    a_mem[5] = 32'hDEAD_BEEF;
    a_mem[9] = 32'h1234;
    #1;
    checks++;
    if (a_data[0] !== 32'hDEAD_BEEF || a_data[1] !== 32'h1234) begin
      failures++;
      $display("FAIL pair_read got=%h/%h exp=deadbeef/00001234", a_data[0], a_data[1]);
    end
    checks++;
    if (a_conf !== 1'b0) begin
      failures++; $display("FAIL pair_conflict got=%0b exp=0", a_conf);
    end
    step();
    $display("txn write_pair: p0 5<=deadbeef p1 9<=1234");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_conflict();
    a_we        = 2'b11;
    a_addrwr[0] = 6'd7;  a_datawr[0] = 32'h0000_AAAA;
    a_addrwr[1] = 6'd7;  a_datawr[1] = 32'h0000_5555;
    a_addr[0]   = 6'd7;  a_addr[1]   = 6'd8;
    #1;
    checks++;
    if (a_data[0] !== 32'h5555 || a_data[1] !== a_mem[8]) begin
      failures++;
      $display("FAIL conflict_bypass got=%h/%h exp=00005555/%h", a_data[0], a_data[1], a_mem[8]);
    end
    step();
    a_we     = '0;
    a_mem[7] = 32'h5555;
    checks++;
    if (a_conf !== 1'b1) begin
      failures++; $display("FAIL conflict_pulse got=%0b exp=1", a_conf);
    end
    #1;
    checks++;
    if (a_data[0] !== 32'h5555) begin
      failures++; $display("FAIL conflict_winner got=%h exp=00005555", a_data[0]);
    end
    step();
    checks++;
    if (a_conf !== 1'b0) begin
      failures++; $display("FAIL conflict_one_cycle got=%0b exp=0", a_conf);
    end
    $display("txn conflict: both ports addr 7, port1 wins");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random_a();
    logic [31:0] exp_rd;
    logic        exp_conf;
    for (int n = 0; n < 300; n++) begin
      a_we = 2'($urandom());
      for (int w = 0; w < 2; w++) begin
        a_addrwr[w] = 6'($urandom_range(0, 15));
        a_datawr[w] = $urandom();
      end
      for (int r = 0; r < 2; r++) begin
        a_addr[r] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 15))
                                                : 6'($urandom_range(0, 63));
      end
      #1;
      for (int r = 0; r < 2; r++) begin
        exp_rd = a_mem[a_addr[r]];
        for (int w = 0; w < 2; w++) begin
          if (a_we[w] && a_addrwr[w] == a_addr[r]) exp_rd = a_datawr[w];
        end
        checks++;
        if (a_data[r] !== exp_rd) begin
          failures++;
          $display("FAIL rand_read n=%0d port=%0d addr=%0d got=%h exp=%h", n, r, a_addr[r], a_data[r], exp_rd);
        end
      end
      exp_conf = (a_we == 2'b11) && (a_addrwr[0] == a_addrwr[1]);
      $display("txn rand n=%0d we=%b wa=%0d/%0d ra=%0d/%0d", n, a_we, a_addrwr[0], a_addrwr[1], a_addr[0], a_addr[1]);
      step();
      for (int w = 0; w < 2; w++) begin
        if (a_we[w]) a_mem[a_addrwr[w]] = a_datawr[w];
      end
      checks++;
      if (a_conf !== exp_conf) begin
        failures++; $display("FAIL rand_conflict n=%0d got=%0b exp=%0b", n, a_conf, exp_conf);
      end
    end
    a_we = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    a_we        = 2'b01;
    a_addrwr[0] = 6'd63;
    a_datawr[0] = 32'hFF;
    step();
    a_we      = '0;
    a_addr[0] = 6'd63;
    #1;
    checks++;
    if (a_data[0] !== 32'hFF) begin
      failures++; $display("FAIL flush_prefill got=%h exp=000000ff", a_data[0]);
    end
    // Flush in READY with a user write in the same cycle.
    a_flush     = 1'b1;
    a_we        = 2'b01;
    a_addrwr[0] = 6'd10;
    a_datawr[0] = 32'h1010;
    step();
    a_flush = 1'b0;
    a_we    = '0;
    checks++;
    if (a_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready_drop got=%0b exp=0", a_ready);
    end
    #1;
    checks++;
    if (a_data[0] !== 32'h0) begin
      failures++; $display("FAIL flush_clear_read got=%h exp=0", a_data[0]);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (a_ready !== 1'b0) begin
        failures++; $display("FAIL flush_mid_ready k=%0d got=%0b exp=0", k, a_ready);
      end
    end
    // Second flush at cycle 20 of the sweep restarts it.
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step();
      checks++;
      if (a_ready !== (k == 63)) begin
        failures++; $display("FAIL flush_restart_ready k=%0d got=%0b exp=%0b", k, a_ready, (k == 63));
      end
    end
    for (int i = 0; i < 64; i++) a_mem[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      a_addr[0] = 6'(2 * i);
      a_addr[1] = 6'(2 * i + 1);
      #1;
      checks++;
      if (a_data[0] !== 32'h0 || a_data[1] !== 32'h0) begin
        failures++;
        $display("FAIL flush_post_read addr=%0d got=%h/%h exp=0", 2 * i, a_data[0], a_data[1]);
      end
      step();
    end
    $display("txn flush: READY flush, restart at sweep cycle 20, array cleared");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_no_bypass();
    logic [31:0] exp_rd;
    logic        exp_conf;
    b_reset_n = 1'b0;
    step();
    step();
    b_reset_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      checks++;
      if (b_ready !== (k == 15)) begin
        failures++; $display("FAIL nb_clear_ready k=%0d got=%0b exp=%0b", k, b_ready, (k == 15));
      end
    end
    for (int i = 0; i < 16; i++) b_mem[i] = 32'h0;
    b_we        = 2'b01;
    b_addrwr[0] = 4'd3;
    b_datawr[0] = 32'h77;
    b_addr[0]   = 4'd3;
    b_addr[1]   = 4'd3;
    #1;
    checks++;
    if (b_data[0] !== 32'h0 || b_data[1] !== 32'h0) begin
      failures++; $display("FAIL nb_same_cycle got=%h/%h exp=0", b_data[0], b_data[1]);
    end
    step();
    b_we     = '0;
    b_mem[3] = 32'h77;
    #1;
    checks++;
    if (b_data[0] !== 32'h77 || b_data[1] !== 32'h77) begin
      failures++; $display("FAIL nb_next_cycle got=%h/%h exp=00000077", b_data[0], b_data[1]);
    end
    step();
    $display("txn no_bypass: 3<=77 visible next cycle only");
    for (int n = 0; n < 100; n++) begin
      b_we = 2'($urandom());
      for (int w = 0; w < 2; w++) begin
        b_addrwr[w] = 4'($urandom_range(0, 7));
        b_datawr[w] = $urandom();
      end
      b_addr[0] = 4'($urandom_range(0, 7));
      b_addr[1] = 4'($urandom_range(0, 15));
      #1;
      for (int r = 0; r < 2; r++) begin
        exp_rd = b_mem[b_addr[r]];
        checks++;
        if (b_data[r] !== exp_rd) begin
          failures++;
          $display("FAIL nb_rand_read n=%0d port=%0d got=%h exp=%h", n, r, b_data[r], exp_rd);
        end
      end
      exp_conf = (b_we == 2'b11) && (b_addrwr[0] == b_addrwr[1]);
      $display("txn nb_rand n=%0d we=%b wa=%0d/%0d", n, b_we, b_addrwr[0], b_addrwr[1]);
      step();
      for (int w = 0; w < 2; w++) begin
        if (b_we[w]) b_mem[b_addrwr[w]] = b_datawr[w];
      end
      checks++;
      if (b_conf !== exp_conf) begin
        failures++; $display("FAIL nb_rand_conflict n=%0d got=%0b exp=%0b", n, b_conf, exp_conf);
      end
    end
    b_we = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_depth48();
    c_reset_n = 1'b0;
    step();
    step();
    c_reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (c_ready !== 1'b0) begin
        failures++; $display("FAIL d48_early_ready k=%0d got=%0b exp=0", k, c_ready);
      end
    end
    // Reset mid-sweep: the full 48-cycle sweep must run again.
    c_reset_n = 1'b0;
    step();
    c_reset_n = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step();
      checks++;
      if (c_ready !== (k == 47)) begin
        failures++; $display("FAIL d48_ready k=%0d got=%0b exp=%0b", k, c_ready, (k == 47));
      end
    end
    for (int i = 0; i < 48; i++) c_mem[i] = C_INIT;
    c_we        = 2'b11;
    c_addrwr[0] = 6'd50; c_datawr[0] = 32'h5050_5050;
    c_addrwr[1] = 6'd47; c_datawr[1] = 32'h0000_4747;
    c_addr[0]   = 6'd50; c_addr[1]   = 6'd47;
    #1;
    checks++;
    if (c_data[0] !== C_INIT || c_data[1] !== 32'h4747) begin
      failures++;
      $display("FAIL d48_bypass got=%h/%h exp=%h/00004747", c_data[0], c_data[1], C_INIT);
    end
    step();
    c_we      = '0;
    c_mem[47] = 32'h4747;
    checks++;
    if (c_conf !== 1'b0) begin
      failures++; $display("FAIL d48_conflict got=%0b exp=0", c_conf);
    end
    c_addr[1] = 6'd63;
    #1;
    checks++;
    if (c_data[0] !== C_INIT || c_data[1] !== C_INIT) begin
      failures++;
      $display("FAIL d48_oor_read got=%h/%h exp=%h", c_data[0], c_data[1], C_INIT);
    end
    for (int i = 0; i < 24; i++) begin
      c_addr[0] = 6'(2 * i);
      c_addr[1] = 6'(2 * i + 1);
      #1;
      checks++;
      if (c_data[0] !== c_mem[2 * i] || c_data[1] !== c_mem[2 * i + 1]) begin
        failures++;
        $display("FAIL d48_array addr=%0d got=%h/%h exp=%h/%h", 2 * i, c_data[0], c_data[1], c_mem[2 * i], c_mem[2 * i + 1]);
      end
      step();
    end
    $display("txn depth48: write 50 dropped, reads of 50/63 give INIT_VAL");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    a_reset_n = 1'b0; a_flush = 1'b0; a_we = '0; a_addr = '0; a_addrwr = '0; a_datawr = '0;
    b_reset_n = 1'b0; b_flush = 1'b0; b_we = '0; b_addr = '0; b_addrwr = '0; b_datawr = '0;
    c_reset_n = 1'b0; c_flush = 1'b0; c_we = '0; c_addr = '0; c_addrwr = '0; c_datawr = '0;
    test_reset();
    test_write_pair();
    test_conflict();
    test_random_a();
    test_flush();
    test_no_bypass();
    test_depth48();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_btb_ram_mp
